// File: rtl/gpio_irq_pkg.sv
// Shared definitions for the GPIO interrupt controller.
// Holds the controller FSM state enumeration and the irq_id width helper.
package gpio_irq_pkg;

    // Controller sequencing: wait for a request, present it, pulse the ack.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Width of an index over n sources; at least one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gpio_irq_ctrl_if.sv
// Bundle between the GPIO block, the CPU and the interrupt controller.
//   src_valid/src_ready/src_mask : per-source request, ack and exclusion
//   irq_valid/irq_ready/irq_id   : interrupt handshake toward the CPU
//   timeout_err/err_clr          : sticky acceptance-timeout flag and its clear
// master = controller side, slave = environment side.
interface gpio_irq_ctrl_if #(
    parameter int unsigned NSRC = 9,
    parameter int unsigned IDW  = 4
);
    logic [NSRC-1:0] src_valid;
    logic [NSRC-1:0] src_ready;
    logic [NSRC-1:0] src_mask;
    logic            irq_valid;
    logic            irq_ready;
    logic [IDW-1:0]  irq_id;
    logic            timeout_err;
    logic            err_clr;

    modport master (
        input  src_valid, src_mask, irq_ready, err_clr,
        output src_ready, irq_valid, irq_id, timeout_err
    );

    modport slave (
        output src_valid, src_mask, irq_ready, err_clr,
        input  src_ready, irq_valid, irq_id, timeout_err
    );
endinterface

// File: rtl/gpio_irq_ctrl_rr_arbiter.sv
// Combinational round-robin picker.
//   req       : request vector
//   last      : index granted most recently
//   gnt_valid : some request is set
//   gnt_idx   : first set request found scanning from last+1, wrapping at N-1
module rr_arbiter #(
    parameter int unsigned N  = 9,
    parameter int unsigned IW = 4
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    int          idx;
    logic [N-1:0] sh;

    // Scan farthest offset first so the nearest requester after last wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        sh        = '0;
        for (int i = int'(N); i >= 1; i--) begin
            idx = (int'(last) + i) % int'(N);
            sh  = req >> idx;
            if (sh[0]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO interrupt controller: arbitrates per-pin and group interrupt sources
// round-robin, presents one at a time to the CPU, acknowledges the source
// with a one-cycle src_ready pulse, and flags a CPU that never accepts.
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : gpio_irq_ctrl_if.master (src_*, irq_*, timeout_err, err_clr)
module gpio_irq_ctrl
    import gpio_irq_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NSRC    = WIDTH + 1,
    parameter int unsigned IDW     = id_width(NSRC),
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           clock,
    input  logic           reset,
    gpio_irq_ctrl_if.master bus
);

    localparam int unsigned CNT_W = 16;

    state_t           state;
    logic             irq_valid_q;
    logic [IDW-1:0]   irq_id_q;
    logic [NSRC-1:0]  src_ready_q;
    logic             timeout_err_q;
    logic [CNT_W-1:0] cnt;
    logic [IDW-1:0]   last_grant;

    logic [NSRC-1:0]  req_c;
    logic             gnt_valid_c;
    logic [IDW-1:0]   gnt_idx_c;

    assign req_c = bus.src_valid & ~bus.src_mask;

    rr_arbiter #(
        .N  (NSRC),
        .IW (IDW)
    ) u_arb (
        .req       (req_c),
        .last      (last_grant),
        .gnt_valid (gnt_valid_c),
        .gnt_idx   (gnt_idx_c)
    );

    // Controller FSM; every output is a register updated here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            irq_valid_q   <= 1'b0;
            irq_id_q      <= '0;
            src_ready_q   <= '0;
            timeout_err_q <= 1'b0;
            cnt           <= '0;
            last_grant    <= IDW'(NSRC - 1);
        end else begin
            src_ready_q <= '0;
            // A timeout below overrides this clear in the same cycle.
            if (bus.err_clr) begin
                timeout_err_q <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (gnt_valid_c) begin
                        state       <= ST_PRESENT;
                        irq_valid_q <= 1'b1;
                        irq_id_q    <= gnt_idx_c;
                        last_grant  <= gnt_idx_c;
                        cnt         <= CNT_W'(TIMEOUT);
                    end
                end
                ST_PRESENT: begin
                    // Acknowledge has priority over an expiring counter.
                    if (bus.irq_ready) begin
                        state       <= ST_RELEASE;
                        irq_valid_q <= 1'b0;
                        src_ready_q <= NSRC'(1) << irq_id_q;
                        cnt         <= '0;
                    end else if (cnt == CNT_W'(1)) begin
                        // Abandon the grant; last_grant keeps the timed-out id.
                        state         <= ST_IDLE;
                        irq_valid_q   <= 1'b0;
                        timeout_err_q <= 1'b1;
                        cnt           <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.irq_valid   = irq_valid_q;
    assign bus.irq_id      = irq_id_q;
    assign bus.src_ready   = src_ready_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Testbench for gpio_irq_ctrl: directed scenarios followed by random traffic,
// all compared every cycle against a transaction-level reference model.
module tb_gpio_irq_ctrl;

    localparam int unsigned NSRC       = 9;
    localparam int unsigned IDW        = 4;
    localparam int          TB_TIMEOUT = 4;

    logic clock;
    logic reset;

    gpio_irq_ctrl_if #(.NSRC(NSRC), .IDW(IDW)) bus ();

    gpio_irq_ctrl #(
        .WIDTH   (8),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: which source is on offer, for how long, and which
    // source is owed its acknowledge pulse.
    bit m_pres;
    int m_id;
    int m_age;
    int m_rel;
    int m_last;
    bit m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input logic [NSRC-1:0] v,
                              input logic [NSRC-1:0] m, input bit r, input bit c);
        logic [NSRC-1:0] req;
        bit              to;
        int              cand;
        to = 1'b0;
        if (rst) begin
            m_pres = 1'b0;
            m_id   = 0;
            m_age  = 0;
            m_rel  = -1;
            m_last = NSRC - 1;
            m_err  = 1'b0;
            return;
        end
        if (m_rel >= 0) begin
            m_rel = -1;
        end else if (m_pres) begin
            m_age++;
            if (r) begin
                m_pres = 1'b0;
                m_rel  = m_id;
            end else if (m_age >= TB_TIMEOUT) begin
                m_pres = 1'b0;
                to     = 1'b1;
            end
        end else begin
            req = v & ~m;
            for (int k = 1; k <= int'(NSRC); k++) begin
                cand = (m_last + k) % int'(NSRC);
                if (((req >> cand) & NSRC'(1)) != '0) begin
                    m_pres = 1'b1;
                    m_id   = cand;
                    m_last = cand;
                    m_age  = 0;
                    break;
                end
            end
        end
        if (to) m_err = 1'b1;
        else if (c) m_err = 1'b0;
    endtask

    task automatic check_all();
        chk("irq_valid", 32'(bus.irq_valid), 32'(m_pres));
        if (m_pres) chk("irq_id", 32'(bus.irq_id), 32'(m_id));
        chk("src_ready", 32'(bus.src_ready), (m_rel >= 0) ? (32'(1) << m_rel) : 32'(0));
        chk("timeout_err", 32'(bus.timeout_err), 32'(m_err));
    endtask

    // One clock: drive inputs, advance model on the edge, compare just after.
    task automatic step(input bit rst, input logic [NSRC-1:0] v,
                        input logic [NSRC-1:0] m, input bit r, input bit c);
        reset         = rst;
        bus.src_valid = v;
        bus.src_mask  = m;
        bus.irq_ready = r;
        bus.err_clr   = c;
        @(posedge clock);
        model_step(rst, v, m, r, c);
        #1;
        check_all();
        @(negedge clock);
    endtask

    initial begin
        logic [NSRC-1:0] rv;
        logic [NSRC-1:0] rm;
        reset         = 1'b1;
        bus.src_valid = '0;
        bus.src_mask  = '0;
        bus.irq_ready = 1'b0;
        bus.err_clr   = 1'b0;

        // Reset state.
        step(1, '0, '0, 0, 0);
        step(1, 9'h1FF, '0, 1, 0);
        chk("rst_irq_valid", 32'(bus.irq_valid), 32'd0);
        chk("rst_irq_id", 32'(bus.irq_id), 32'd0);
        chk("rst_src_ready", 32'(bus.src_ready), 32'd0);
        chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);

        // Single request, single acknowledge.
        step(0, 9'h004, '0, 0, 0);
        chk("single_valid", 32'(bus.irq_valid), 32'd1);
        chk("single_id", 32'(bus.irq_id), 32'd2);
        step(0, 9'h004, '0, 1, 0);
        chk("single_ready", 32'(bus.src_ready), 32'h004);
        chk("single_valid_drop", 32'(bus.irq_valid), 32'd0);
        step(0, '0, '0, 0, 0);
        chk("single_ready_once", 32'(bus.src_ready), 32'h000);

        // All sources requesting, CPU always ready: 0..8,0 at one per 3 cycles.
        step(1, '0, '0, 0, 0);
        for (int k = 0; k < 30; k++) begin
            step(0, 9'h1FF, '0, 1, 0);
            chk("rr_valid", 32'(bus.irq_valid), (k % 3 == 0) ? 32'd1 : 32'd0);
            if (k % 3 == 0) chk("rr_id", 32'(bus.irq_id), 32'((k / 3) % 9));
        end

        // Masked source skipped; grant survives mask/valid changes.
        step(1, '0, '0, 0, 0);
        step(0, 9'h003, 9'h001, 0, 0);
        chk("mask_id", 32'(bus.irq_id), 32'd1);
        step(0, 9'h003, 9'h1FF, 0, 0);
        chk("mask_hold_id", 32'(bus.irq_id), 32'd1);
        step(0, 9'h000, 9'h000, 0, 0);
        chk("mask_hold_valid", 32'(bus.irq_valid), 32'd1);
        step(0, 9'h000, 9'h000, 1, 0);
        chk("mask_ack", 32'(bus.src_ready), 32'h002);
        step(0, '0, '0, 0, 0);

        // Everything masked: nothing happens.
        for (int k = 0; k < 8; k++) step(0, 9'h1FF, 9'h1FF, 1, 0);
        chk("allmask_valid", 32'(bus.irq_valid), 32'd0);

        // Timeout after TB_TIMEOUT presented cycles; next grant rotates past.
        step(1, '0, '0, 0, 0);
        step(0, 9'h011, '0, 0, 0);
        chk("to_first_id", 32'(bus.irq_id), 32'd0);
        for (int k = 0; k < TB_TIMEOUT - 1; k++) step(0, 9'h011, '0, 0, 0);
        chk("to_still_valid", 32'(bus.irq_valid), 32'd1);
        step(0, 9'h011, '0, 0, 0);
        chk("to_valid_drop", 32'(bus.irq_valid), 32'd0);
        chk("to_err_set", 32'(bus.timeout_err), 32'd1);
        chk("to_no_ready", 32'(bus.src_ready), 32'd0);
        step(0, 9'h011, '0, 0, 0);
        chk("to_next_id", 32'(bus.irq_id), 32'd4);
        step(0, 9'h011, '0, 1, 1);
        chk("to_err_clr", 32'(bus.timeout_err), 32'd0);
        chk("to_ack4", 32'(bus.src_ready), 32'h010);

        // err_clr held across a timeout: the error still ends set.
        step(0, 9'h001, '0, 0, 1);
        step(0, 9'h001, '0, 0, 1);
        for (int k = 0; k < TB_TIMEOUT; k++) step(0, 9'h001, '0, 0, 1);
        chk("clr_vs_to", 32'(bus.timeout_err), 32'd1);

        // Ready on the final counted cycle wins over the timeout.
        step(0, 9'h002, '0, 0, 1);
        for (int k = 0; k < TB_TIMEOUT - 1; k++) step(0, 9'h002, '0, 0, 0);
        step(0, 9'h002, '0, 1, 0);
        chk("ready_wins_ack", 32'(bus.src_ready), 32'h002);
        chk("ready_wins_err", 32'(bus.timeout_err), 32'd0);
        step(0, '0, '0, 0, 0);

        // Reset during PRESENT abandons the grant; arbitration restarts at 0.
        step(1, '0, '0, 0, 0);
        step(0, 9'h020, '0, 0, 0);
        chk("rstp_id", 32'(bus.irq_id), 32'd5);
        step(1, 9'h020, '0, 1, 0);
        chk("rstp_valid", 32'(bus.irq_valid), 32'd0);
        chk("rstp_ready", 32'(bus.src_ready), 32'd0);
        step(0, 9'h021, '0, 0, 0);
        chk("rstp_first", 32'(bus.irq_id), 32'd0);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            rv = NSRC'($urandom) & NSRC'($urandom);
            rm = NSRC'($urandom) & NSRC'($urandom) & NSRC'($urandom);
            step(($urandom_range(0, 99) == 0), rv, rm,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_irq_ctrl.md
GPIO_IRQ_CTRL -- requirements
Module: gpio_irq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of GPIO pins served.
REQ-002 SHALL have parameter NSRC, default WIDTH+1, interrupt sources (per-pin plus group source at index WIDTH).
REQ-003 SHALL have parameter IDW, default clog2(NSRC) (4 for NSRC=9), width of irq_id.
REQ-004 SHALL have parameter TIMEOUT, default 255, max PRESENT cycles without irq_ready, range 1..65535.
REQ-005 SHALL have port clock  input  1  clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port src_valid  input  NSRC  per-source interrupt request from the GPIO block (ir_valid).
REQ-008 SHALL have port src_ready  output  NSRC  per-source acknowledge to the GPIO block (ir_ready).
REQ-009 SHALL have port src_mask  input  NSRC  1 = source excluded from arbitration.
REQ-010 SHALL have port irq_valid  output  1  interrupt presented to CPU.
REQ-011 SHALL have port irq_ready  input  1  CPU accepts presented interrupt.
REQ-012 SHALL have port irq_id  output  IDW  index of presented source.
REQ-013 SHALL have port timeout_err  output  1  sticky flag, CPU failed to accept within TIMEOUT.
REQ-014 SHALL have port err_clr  input  1  clears timeout_err.

Function
REQ-015 SHALL implement FSM states IDLE, PRESENT, RELEASE; all outputs registered.
REQ-016 IDLE: if any (src_valid & ~src_mask) is set, SHALL grant one source round-robin, starting at last_grant+1, wrapping NSRC-1 to 0, then go to PRESENT; otherwise stay in IDLE.
REQ-017 On grant SHALL load irq_id and last_grant with the granted index and set irq_valid; irq_valid rises the cycle after src_valid is sampled in IDLE (latency 1).
REQ-018 PRESENT: irq_valid and irq_id SHALL hold stable until irq_ready or timeout; changes to src_mask or src_valid during PRESENT SHALL NOT revoke or change the grant.
REQ-019 PRESENT with irq_ready=1: SHALL clear irq_valid, pulse src_ready[irq_id] high for exactly one cycle (next cycle), and go to RELEASE.
REQ-020 RELEASE: SHALL hold src_ready one-hot at irq_id for that single cycle, then return to IDLE; src_ready SHALL be zero in all other states.
REQ-021 Back-to-back service: irq_ready at cycle M gives src_ready at M+1, IDLE at M+2, next irq_valid no earlier than M+3.
REQ-022 A down-counter SHALL load TIMEOUT on entry to PRESENT and decrement each PRESENT cycle without irq_ready; at zero SHALL clear irq_valid, set timeout_err, return to IDLE without pulsing src_ready, keep last_grant as the timed-out index so the next grant rotates past it.
REQ-023 irq_ready and timeout in the same cycle: irq_ready SHALL win (normal acknowledge, no error).
REQ-024 err_clr and a timeout event in the same cycle: timeout_err SHALL end set.
REQ-025 irq_ready while irq_valid=0 SHALL be ignored.
REQ-026 All sources masked or idle: SHALL remain in IDLE with irq_valid=0 indefinitely.

Reset
REQ-027 On reset SHALL enter IDLE with irq_valid=0, irq_id=0, src_ready=0, timeout_err=0, counter=0, last_grant=NSRC-1 (source 0 highest priority first).
REQ-028 Reset asserted in any state SHALL take effect at the next edge, abandoning any grant without src_ready.

Structure
REQ-029 Shared package gpio_irq_pkg SHALL hold the FSM state enumeration and the IDW/clog2 helper.
REQ-030 Round-robin selection SHALL be a combinational sub-module rr_arbiter (request vector, last pointer -> grant valid, grant index).

Verification
REQ-031 Reset, then src_valid=9'h004 -> irq_valid=1, irq_id=2 one cycle later; irq_ready=1 -> src_ready=9'h004 for exactly one cycle.
REQ-032 src_valid=9'h1FF held, irq_ready always 1 -> irq_id sequence 0,1,2,...,8,0, one grant per 3 cycles.
REQ-033 src_valid=9'h003, src_mask=9'h001 -> only id 1 granted; mask change mid-PRESENT leaves irq_id unchanged.
REQ-034 TIMEOUT=4, src_valid=9'h011, irq_ready=0 -> irq_valid drops after 4 PRESENT cycles, timeout_err=1, no src_ready, next grant id 4; err_clr=1 -> timeout_err=0.
REQ-035 Reset asserted during PRESENT with id 5 -> next cycle irq_valid=0, src_ready=0; after release with src_valid=9'h021, first grant id 0.
